instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 185 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: one-hot RV32IM operation select plus fields -> 32-bit instruction word,
// queued in a small output FIFO. Define IMM_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [46:0]      op_sel,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] instr_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

  logic [5:0]  op_idx;
  logic        one_hot;
  fmt_e        fmt;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] word;
  logic        imm_ok;
  logic        accept, push, pop, reject;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             err_q;

  always_comb begin
    op_idx = '0;
    for (int i = 0; i < 47; i++) begin
      if (op_sel[i]) op_idx = 6'(i);
    end
  end

  assign one_hot = (op_sel != '0) && ((op_sel & (op_sel - 47'd1)) == '0);

  // Format, opcode and func7 follow the contiguous groups of the op_sel bit map.
  always_comb begin
    fmt = FMT_R;
    opc = 7'b0110011;
    f7  = 7'h00;
    if (op_idx <= 6'd9) begin
      f7 = (op_idx == 6'd1 || op_idx == 6'd7) ? 7'h20 : 7'h00;
    end else if (op_idx >= 6'd14 && op_idx <= 6'd16) begin
      fmt = FMT_SH; opc = 7'b0010011;
      f7  = (op_idx == 6'd16) ? 7'h20 : 7'h00;
    end else if (op_idx <= 6'd18) begin
      fmt = FMT_I; opc = 7'b0010011;
    end else if (op_idx <= 6'd23) begin
      fmt = FMT_I; opc = 7'b0000011;
    end else if (op_idx <= 6'd26) begin
      fmt = FMT_S; opc = 7'b0100011;
    end else if (op_idx <= 6'd32) begin
      fmt = FMT_B; opc = 7'b1100011;
    end else if (op_idx == 6'd33) begin
      fmt = FMT_J; opc = 7'b1101111;
    end else if (op_idx == 6'd34) begin
      fmt = FMT_I; opc = 7'b1100111;
    end else if (op_idx == 6'd35) begin
      fmt = FMT_U; opc = 7'b0110111;
    end else if (op_idx == 6'd36) begin
      fmt = FMT_U; opc = 7'b0010111;
    end else if (op_idx <= 6'd38) begin
      fmt = FMT_SYS; opc = 7'b1110011;
    end else begin
      f7 = 7'h01;
    end
  end

  always_comb begin
    case (op_idx)
      6'd5, 6'd14, 6'd20, 6'd25, 6'd28, 6'd40:         f3 = 3'd1;
      6'd8, 6'd17, 6'd21, 6'd26, 6'd41:                f3 = 3'd2;
      6'd9, 6'd18, 6'd42:                              f3 = 3'd3;
      6'd2, 6'd11, 6'd22, 6'd29, 6'd43:                f3 = 3'd4;
      6'd6, 6'd7, 6'd15, 6'd16, 6'd23, 6'd30, 6'd44:   f3 = 3'd5;
      6'd3, 6'd12, 6'd31, 6'd45:                       f3 = 3'd6;
      6'd4, 6'd13, 6'd32, 6'd46:                       f3 = 3'd7;
      default:                                         f3 = 3'd0;
    endcase
  end

  always_comb begin
    case (fmt)
      FMT_R:   word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:   word = {imm[11:0], rs1, f3, rd, opc};
      FMT_SH:  word = {f7, imm[4:0], rs1, f3, rd, opc};
      FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_U:   word = {imm[19:0], rd, opc};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: word = {11'd0, (op_idx == 6'd38), 13'd0, opc};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Upper immediate bits must be a pure sign extension of the encodable field.
  always_comb begin
    case (fmt)
      FMT_I, FMT_S: imm_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
      FMT_SH:       imm_ok = (imm[31:5] == '0);
      FMT_B:        imm_ok = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
      FMT_J:        imm_ok = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));
      FMT_U:        imm_ok = (imm[31:20] == '0);
      default:      imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  logic unused_imm;
  assign unused_imm = ^imm[31:21];

  assign accept = in_valid && in_ready;
  assign push   = accept && one_hot && imm_ok;
  assign reject = accept && !(one_hot && imm_ok);
  assign pop    = out_valid && out_ready;

  always_comb begin
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_cnt_d = err_cnt_q;
    icnt_d    = icnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      icnt_d   = icnt_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (reject && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
      icnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
      icnt_q    <= icnt_d;
      err_q     <= reject;
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign in_ready    = (cnt_q < FULL);
  assign out_valid   = (cnt_q != '0);
  assign out_instr   = out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign err         = err_q;
  assign err_count   = err_cnt_q;
  assign instr_count = icnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32IM words, FIFO backpressure,
// rejects, err_count saturation and asynchronous reset mid-stream.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [46:0] op_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  instr_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .err_count(err_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_instr);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [46:0] op(input int i);
    return 47'd1 << i;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [46:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    int t;
    op_sel = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) check_val("send_timeout", 32'(in_ready), 32'd1);
    else tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    tick(8);
    check_val({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) check_val(tag, (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_sel = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_instr", out_instr, 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    check_val("rst_instr_count", 32'(instr_count), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1, x0, 5 with one-cycle latency
    out_ready = 1'b1;
    send(op(10), 5'd1, 5'd0, 5'd0, 32'd5);
    check_val("addi_out_valid", 32'(out_valid), 32'd1);
    check_val("addi_out_instr", out_instr, 32'h00500093);
    check_val("addi_instr_count", 32'(instr_count), 32'd1);
    exp_q.push_back(32'h00500093);
    drain_check("addi");

    // back-to-back R/S/B
    send(op(0),  5'd3, 5'd1, 5'd2, 32'd0);
    send(op(26), 5'd0, 5'd1, 5'd2, 32'd8);
    send(op(27), 5'd0, 5'd1, 5'd2, 32'd16);
    exp_q = '{32'h002081B3, 32'h0020A423, 32'h00208863};
    drain_check("rsb");
    check_val("rsb_instr_count", 32'(instr_count), 32'd4);

    // J, system, negative branch, M-extension
    send(op(33), 5'd1, 5'd0, 5'd0, 32'd2048);
    send(op(37), 5'd7, 5'd7, 5'd7, 32'd0);
    send(op(28), 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    send(op(38), 5'd0, 5'd0, 5'd0, 32'd0);
    send(op(39), 5'd1, 5'd2, 5'd3, 32'd0);
    exp_q = '{32'h001000EF, 32'h00000073, 32'hFE001EE3, 32'h00100073, 32'h023100B3};
    drain_check("jsys");
    check_val("jsys_instr_count", 32'(instr_count), 32'd9);

    // backpressure: fill, hold third request, then release
    out_ready = 1'b0;
    send(op(10), 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF);
    check_val("bp_ready_after1", 32'(in_ready), 32'd1);
    send(op(35), 5'd5, 5'd0, 5'd0, 32'h00012345);
    check_val("bp_ready_full", 32'(in_ready), 32'd0);
    fork
      send(op(16), 5'd1, 5'd1, 5'd0, 32'd3);
    join_none
    tick(3);
    check_val("bp_ready_held", 32'(in_ready), 32'd0);
    check_val("bp_head_stable", out_instr, 32'hFFF08113);
    check_val("bp_count_held", 32'(instr_count), 32'd11);
    out_ready = 1'b1;
    exp_q = '{32'hFFF08113, 32'h123452B7, 32'h4030D093};
    drain_check("bp");
    check_val("bp_instr_count", 32'(instr_count), 32'd12);

    // rejected requests
    send('0, 5'd1, 5'd1, 5'd1, 32'd0);
    check_val("rej0_err", 32'(err), 32'd1);
    check_val("rej0_err_count", 32'(err_count), 32'd1);
    tick(1);
    check_val("rej0_err_drop", 32'(err), 32'd0);
    send(op(0) | op(1), 5'd1, 5'd1, 5'd1, 32'd0);
    check_val("rej2_err", 32'(err), 32'd1);
    check_val("rej2_err_count", 32'(err_count), 32'd2);
    check_val("rej2_out_valid", 32'(out_valid), 32'd0);
    tick(1);
    check_val("rej2_err_drop", 32'(err), 32'd0);
    check_val("rej_instr_count", 32'(instr_count), 32'd12);
    drain_check("rej");

    // addi with oversized immediate
    send(op(10), 5'd0, 5'd0, 5'd0, 32'd4096);
`ifdef IMM_RANGE_CHECK_EN
    check_val("rng_err", 32'(err), 32'd1);
    check_val("rng_err_count", 32'(err_count), 32'd3);
    check_val("rng_out_valid", 32'(out_valid), 32'd0);
    check_val("rng_instr_count", 32'(instr_count), 32'd12);
    drain_check("rng");
`else
    check_val("trunc_err", 32'(err), 32'd0);
    check_val("trunc_instr_count", 32'(instr_count), 32'd13);
    exp_q.push_back(32'h00000013);
    drain_check("trunc");
`endif

    // asynchronous reset while a word is queued
    out_ready = 1'b0;
    send(op(10), 5'd1, 5'd0, 5'd0, 32'd5);
    check_val("mid_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_out_instr", out_instr, 32'd0);
    check_val("mid_rst_instr_count", 32'(instr_count), 32'd0);
    check_val("mid_rst_err_count", 32'(err_count), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("post_rst_out_valid", 32'(out_valid), 32'd0);

    // err_count saturation
    out_ready = 1'b1;
    for (int k = 0; k < 260; k++) send('0, 5'd0, 5'd0, 5'd0, 32'd0);
    check_val("sat_err_count", 32'(err_count), 32'd255);
    send(op(4), 5'd3, 5'd1, 5'd2, 32'd0);
    exp_q.push_back(32'h0020F1B3);
    drain_check("post_sat");
    check_val("post_sat_instr_count", 32'(instr_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
